// File: rtl/exe_stage_pipelined_if.sv
// Handshake and data bus of the execute stage: ID/EX request side, MEM result side and flush.
interface exe_stage_pipelined_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 24,
  parameter int unsigned TAG_W  = 4
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] val_rn;
  logic [DATA_W-1:0] val2;
  logic [3:0]        exe_cmd;
  logic [IMM_W-1:0]  signed_imm;
  logic              c_in;
  logic              s_in;
  logic              wb_en_in;
  logic              mem_read_in;
  logic              mem_write_in;
  logic [TAG_W-1:0]  tag_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] branch_addr;
  logic [3:0]        status_bits;
  logic              status_we;
  logic              s_out;
  logic              wb_en_out;
  logic              mem_read_out;
  logic              mem_write_out;
  logic [TAG_W-1:0]  tag_out;

  modport master (
    output flush, in_valid, pc_in, val_rn, val2, exe_cmd, signed_imm, c_in,
           s_in, wb_en_in, mem_read_in, mem_write_in, tag_in, out_ready,
    input  in_ready, out_valid, alu_result, branch_addr, status_bits, status_we,
           s_out, wb_en_out, mem_read_out, mem_write_out, tag_out
  );

  modport slave (
    input  flush, in_valid, pc_in, val_rn, val2, exe_cmd, signed_imm, c_in,
           s_in, wb_en_in, mem_read_in, mem_write_in, tag_in, out_ready,
    output in_ready, out_valid, alu_result, branch_addr, status_bits, status_we,
           s_out, wb_en_out, mem_read_out, mem_write_out, tag_out
  );
endinterface

// File: rtl/exe_stage_pipelined.sv
// Execute stage: single-cycle ALU, iterative shift-add MUL, branch target, registered
// result toward MEM with valid/ready handshake on both sides.
module exe_stage_pipelined #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned IMM_W    = 24,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned MUL_BITS = 1
) (
  input logic                 clk,
  input logic                 rst,
  exe_stage_pipelined_if.slave bus
);
  localparam int unsigned STEPS = DATA_W / MUL_BITS;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);
  localparam logic [3:0]  CMD_MUL = 4'b1010;
  localparam int unsigned M = DATA_W - 1;

  typedef enum logic {IDLE, MUL} state_t;
  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] mcand_q, mplier_q, acc_q, acc_step, pp_mcand, pp_mplier;
  logic [DATA_W-1:0] m_branch_q;
  logic              m_c_q, m_s_q, m_wb_q, m_mr_q, m_mw_q;
  logic [TAG_W-1:0]  m_tag_q;

  logic              accept, is_mul, mul_last, load_out, in_ready;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] alu_res, off_ext, branch_calc, load_res, load_branch;
  logic              alu_c, alu_v;
  logic [3:0]        load_flags;

  logic              ov_q, s_q, wb_q, mr_q, mw_q;
  logic [DATA_W-1:0] res_q, br_q;
  logic [3:0]        flags_q;
  logic [TAG_W-1:0]  tag_q;

  assign is_mul   = (bus.exe_cmd == CMD_MUL);
  assign in_ready = (state_q == IDLE) & (~ov_q | bus.out_ready) & ~bus.flush;
  assign accept   = bus.in_valid & in_ready;
  assign mul_last = (state_q == MUL) && (cnt_q == CNT_W'(1));
  assign load_out = (accept & ~is_mul) | (mul_last & ~bus.flush);

  assign off_ext     = DATA_W'($signed(bus.signed_imm));
  assign branch_calc = bus.pc_in + (off_ext << 2);

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = bus.c_in;
    alu_v   = 1'b0;
    case (bus.exe_cmd)
      4'b0001: alu_res = bus.val2;
      4'b1001: alu_res = ~bus.val2;
      4'b0010, 4'b0011: begin
        sum     = {1'b0, bus.val_rn} + {1'b0, bus.val2}
                + {{DATA_W{1'b0}}, (bus.exe_cmd[0] & bus.c_in)};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = (bus.val_rn[M] == bus.val2[M]) && (alu_res[M] != bus.val_rn[M]);
      end
      4'b0100, 4'b0101: begin
        // A - B - borrow as A + ~B + carry, so the carry-out is directly "not borrow"
        sum     = {1'b0, bus.val_rn} + {1'b0, ~bus.val2}
                + {{DATA_W{1'b0}}, (bus.exe_cmd[0] ? bus.c_in : 1'b1)};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = (bus.val_rn[M] != bus.val2[M]) && (alu_res[M] != bus.val_rn[M]);
      end
      4'b0110: alu_res = bus.val_rn & bus.val2;
      4'b0111: alu_res = bus.val_rn | bus.val2;
      4'b1000: alu_res = bus.val_rn ^ bus.val2;
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
    endcase
  end

  always_comb begin
    acc_step  = acc_q;
    pp_mcand  = mcand_q;
    pp_mplier = mplier_q;
    for (int unsigned i = 0; i < MUL_BITS; i++) begin
      if (pp_mplier[0]) acc_step = acc_step + pp_mcand;
      pp_mcand  = pp_mcand << 1;
      pp_mplier = pp_mplier >> 1;
    end
  end

  always_comb begin
    if (mul_last) begin
      load_res    = acc_step;
      load_branch = m_branch_q;
      load_flags  = {acc_step[M], (acc_step == '0), m_c_q, 1'b0};
    end else begin
      load_res    = alu_res;
      load_branch = branch_calc;
      load_flags  = {alu_res[M], (alu_res == '0), alu_c, alu_v};
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (accept && is_mul) state_d = MUL;
        MUL:     if (mul_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0; mcand_q <= '0; mplier_q <= '0; acc_q <= '0; m_branch_q <= '0;
      m_c_q <= 1'b0; m_s_q <= 1'b0; m_wb_q <= 1'b0; m_mr_q <= 1'b0; m_mw_q <= 1'b0;
      m_tag_q <= '0;
    end else if (bus.flush) begin
      cnt_q <= '0;
    end else if (accept && is_mul) begin
      cnt_q <= CNT_W'(STEPS);
      mcand_q <= bus.val_rn; mplier_q <= bus.val2; acc_q <= '0; m_branch_q <= branch_calc;
      m_c_q <= bus.c_in; m_s_q <= bus.s_in; m_wb_q <= bus.wb_en_in;
      m_mr_q <= bus.mem_read_in; m_mw_q <= bus.mem_write_in; m_tag_q <= bus.tag_in;
    end else if (state_q == MUL) begin
      cnt_q    <= cnt_q - 1'b1;
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << MUL_BITS;
      mplier_q <= mplier_q >> MUL_BITS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q <= 1'b0; res_q <= '0; br_q <= '0; flags_q <= '0;
      s_q <= 1'b0; wb_q <= 1'b0; mr_q <= 1'b0; mw_q <= 1'b0; tag_q <= '0;
    end else if (bus.flush) begin
      ov_q <= 1'b0;
    end else if (load_out) begin
      ov_q <= 1'b1; res_q <= load_res; br_q <= load_branch; flags_q <= load_flags;
      s_q   <= mul_last ? m_s_q   : bus.s_in;
      wb_q  <= mul_last ? m_wb_q  : bus.wb_en_in;
      mr_q  <= mul_last ? m_mr_q  : bus.mem_read_in;
      mw_q  <= mul_last ? m_mw_q  : bus.mem_write_in;
      tag_q <= mul_last ? m_tag_q : bus.tag_in;
    end else if (bus.out_ready) begin
      ov_q <= 1'b0;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = ov_q;
  assign bus.alu_result    = res_q;
  assign bus.branch_addr   = br_q;
  assign bus.status_bits   = flags_q;
  assign bus.status_we     = s_q & ov_q;
  assign bus.s_out         = s_q;
  assign bus.wb_en_out     = wb_q;
  assign bus.mem_read_out  = mr_q;
  assign bus.mem_write_out = mw_q;
  assign bus.tag_out       = tag_q;
endmodule

// File: tb/tb_exe_stage_pipelined.sv
// Bench for exe_stage_pipelined: directed literal cases plus randomized traffic against a
// transaction-level model of the stage.
module tb_exe_stage_pipelined;
  localparam int unsigned DW = 32, IW = 24, TW = 4, MB = 4, STEPS = DW / MB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_stage_pipelined_if #(.DATA_W(DW), .IMM_W(IW), .TAG_W(TW)) bus ();
  exe_stage_pipelined #(.DATA_W(DW), .IMM_W(IW), .TAG_W(TW), .MUL_BITS(MB)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] br;
    logic [3:0]  f;
    logic        s, wb, mr, mw;
    logic [3:0]  tag;
  } out_t;

  int nchk = 0, nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference semantics straight from the op table, using wide integer arithmetic.
  function automatic out_t predict();
    out_t o;
    logic [31:0] a, b, r;
    logic [63:0] p;
    longint sa, sb, sr;
    logic c, v;
    a = bus.val_rn; b = bus.val2;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    c = bus.c_in; v = 1'b0; r = '0; sr = 0;
    case (bus.exe_cmd)
      4'h1: r = b;
      4'h9: r = ~b;
      4'h2, 4'h3: begin
        sr = sa + sb + ((bus.exe_cmd == 4'h3 && bus.c_in) ? 1 : 0);
        p  = 64'(a) + 64'(b) + ((bus.exe_cmd == 4'h3 && bus.c_in) ? 64'd1 : 64'd0);
        r = p[31:0]; c = p[32];
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'h4, 4'h5: begin
        sr = sa - sb - ((bus.exe_cmd == 4'h5 && !bus.c_in) ? 1 : 0);
        p  = 64'(b) + ((bus.exe_cmd == 4'h5 && !bus.c_in) ? 64'd1 : 64'd0);
        r = a - p[31:0];
        c = (64'(a) >= p);
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'h6: r = a & b;
      4'h7: r = a | b;
      4'h8: r = a ^ b;
      4'hA: begin p = 64'(a) * 64'(b); r = p[31:0]; end
      default: begin r = '0; c = 1'b0; end
    endcase
    o.res = r;
    o.br  = bus.pc_in + ({{8{bus.signed_imm[23]}}, bus.signed_imm} << 2);
    o.f   = {r[31], (r == 0), c, v};
    o.s = bus.s_in; o.wb = bus.wb_en_in; o.mr = bus.mem_read_in; o.mw = bus.mem_write_in;
    o.tag = bus.tag_in;
    return o;
  endfunction

  bit   m_ov, m_busy, m_acc;
  int   m_rem;
  out_t m_out, m_pend;

  function automatic bit model_ready();
    return !m_busy && (!m_ov || bus.out_ready) && !bus.flush;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ov = 0; m_busy = 0; m_rem = 0; m_out = '0; m_pend = '0;
    end else begin
      m_acc = bus.in_valid && model_ready();
      if (bus.flush) begin
        m_ov = 0; m_busy = 0;
      end else if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin m_busy = 0; m_out = m_pend; m_ov = 1; end
      end else if (m_acc) begin
        if (bus.exe_cmd == 4'hA) begin
          m_busy = 1; m_rem = STEPS; m_pend = predict(); m_ov = 0;
        end else begin
          m_out = predict(); m_ov = 1;
        end
      end else if (bus.out_ready) m_ov = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 32'(bus.in_ready), 32'(model_ready()));
      chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
      chk("status_we", 32'(bus.status_we), 32'(m_ov && m_out.s));
      if (m_ov) begin
        chk("alu_result", bus.alu_result, m_out.res);
        chk("branch_addr", bus.branch_addr, m_out.br);
        chk("status_bits", 32'(bus.status_bits), 32'(m_out.f));
        chk("sideband", {24'd0, bus.s_out, bus.wb_en_out, bus.mem_read_out, bus.mem_write_out, bus.tag_out},
            {24'd0, m_out.s, m_out.wb, m_out.mr, m_out.mw, m_out.tag});
      end
    end
  end

  task automatic set_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic s, input logic [31:0] pc, input logic [23:0] imm);
    bus.exe_cmd = cmd; bus.val_rn = a; bus.val2 = b; bus.c_in = cin; bus.s_in = s;
    bus.pc_in = pc; bus.signed_imm = imm; bus.tag_in = 4'h5; bus.wb_en_in = 1'b1;
    bus.mem_read_in = 1'b0; bus.mem_write_in = 1'b0;
  endtask

  task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic s, input logic [31:0] pc, input logic [23:0] imm);
    set_op(cmd, a, b, cin, s, pc, imm);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  int n, low;

  initial begin
    rst = 1'b1;
    bus.flush = 0; bus.in_valid = 0; bus.out_ready = 1;
    set_op(4'h0, 0, 0, 0, 0, 0, 0);
    step(2);
    rst = 1'b0;
    #1;
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst alu_result", bus.alu_result, 0);
    chk("rst branch_addr", bus.branch_addr, 0);
    chk("rst status_bits", 32'(bus.status_bits), 0);
    chk("rst in_ready", 32'(bus.in_ready), 1);

    issue(4'h2, 5, 7, 0, 0, 0, 0);
    chk("add result", bus.alu_result, 12);
    chk("add flags", 32'(bus.status_bits), 32'h0);
    chk("add valid", 32'(bus.out_valid), 1);
    step(1);
    chk("add valid drop", 32'(bus.out_valid), 0);

    issue(4'h4, 3, 3, 0, 1, 0, 0);
    chk("sub result", bus.alu_result, 0);
    chk("sub flags", 32'(bus.status_bits), 32'h6);
    chk("sub status_we", 32'(bus.status_we), 1);

    issue(4'h2, 32'h7FFFFFFF, 1, 0, 0, 0, 0);
    chk("ovf result", bus.alu_result, 32'h80000000);
    chk("ovf flags", 32'(bus.status_bits), 32'h9);

    issue(4'h1, 0, 0, 0, 0, 32'h100, 24'hFFFFFF);
    chk("branch neg", bus.branch_addr, 32'hFC);
    issue(4'h1, 0, 0, 0, 0, 32'h100, 24'h000004);
    chk("branch pos", bus.branch_addr, 32'h110);
    issue(4'h1, 0, 0, 0, 0, 32'hFFFFFFFC, 24'h000001);
    chk("branch wrap", bus.branch_addr, 32'h0);

    issue(4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0, 0);
    n = 0; low = 0;
    while (!bus.out_valid && n < 100) begin
      if (!bus.in_ready) low++;
      step(1); n++;
    end
    chk("mul busy cycles", 32'(low), 32'(STEPS));
    chk("mul latency", 32'(n + 1), 32'(STEPS + 1));
    chk("mul result", bus.alu_result, 32'h1);
    chk("mul flags", 32'(bus.status_bits), 32'h2);
    step(1);

    bus.out_ready = 0;
    issue(4'h2, 10, 20, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("hold result", bus.alu_result, 30);
      chk("hold valid", 32'(bus.out_valid), 1);
      chk("hold in_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1;
    issue(4'h4, 50, 8, 0, 0, 0, 0);
    chk("b2b valid", 32'(bus.out_valid), 1);
    chk("b2b result", bus.alu_result, 42);
    step(1);

    issue(4'hA, 3, 5, 0, 0, 0, 0);
    step(3);
    bus.flush = 1; #1;
    chk("flush in_ready", 32'(bus.in_ready), 0);
    step(1);
    bus.flush = 0; #1;
    chk("flush valid", 32'(bus.out_valid), 0);
    chk("flush in_ready after", 32'(bus.in_ready), 1);
    for (int i = 0; i < int'(STEPS) + 2; i++) begin
      step(1);
      chk("flush no result", 32'(bus.out_valid), 0);
    end
    issue(4'h2, 1, 2, 0, 0, 0, 0);
    chk("post flush add", bus.alu_result, 3);
    chk("post flush valid", 32'(bus.out_valid), 1);

    issue(4'hA, 7, 9, 0, 1, 32'h40, 24'h10);
    step(2);
    #2 rst = 1'b1; #1;
    chk("rst mid-mul result", bus.alu_result, 0);
    chk("rst mid-mul branch", bus.branch_addr, 0);
    chk("rst mid-mul valid", 32'(bus.out_valid), 0);
    chk("rst mid-mul we", 32'(bus.status_we), 0);
    chk("rst mid-mul in_ready", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;

    repeat (3000) begin
      set_op($urandom_range(0, 3) == 0 ? 4'hA : 4'($urandom_range(0, 15)),
             rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             rnd_val(), 24'($urandom()));
      bus.tag_in = 4'($urandom_range(0, 15));
      bus.wb_en_in = 1'($urandom_range(0, 1));
      bus.mem_read_in = 1'($urandom_range(0, 1));
      bus.mem_write_in = 1'($urandom_range(0, 1));
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush = ($urandom_range(0, 31) == 0);
      step(1);
    end
    bus.in_valid = 0; bus.flush = 0; bus.out_ready = 1;
    step(STEPS + 3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
